// File: rtl/rat_pkg.sv
// Shared types and constants for the rational-arithmetic operator family.
package rat_pkg;

    localparam int unsigned RAT_WIDTH = 32;

    typedef struct packed {
        logic [RAT_WIDTH-1:0] num;
        logic [RAT_WIDTH-1:0] den;
    } rat_t;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StStrip,
        StGcd,
        StDivn,
        StDivd,
        StDone
    } rat_reduce_state_e;

endpackage

// File: rtl/rat_divu.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses WIDTH cycles after start.
module rat_divu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;

    // rem < divisor always holds, so the top bit of diff is a clean borrow flag.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, divisor};
        fits  = ~diff[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                quo_q  <= dividend;
                rem_q  <= '0;
                cnt_q  <= CW'(WIDTH);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                quo_q <= {quo_q[WIDTH-2:0], fits};
                rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign done = done_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces num/den to lowest terms: binary GCD, then divides both terms by the GCD.
module rat_reduce
    import rat_pkg::*;
#(
    parameter int unsigned WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_dz,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    rat_reduce_state_e state_q;

    logic [WIDTH-1:0] n0_q;
    logic [WIDTH-1:0] d0_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] g_q;
    logic             div_start_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] out_num_q;
    logic [WIDTH-1:0] out_den_q;
    logic             out_dz_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_done;

    // One divider serves both passes; the current state picks the dividend.
    assign div_dividend = (state_q == StDivd) ? d0_q : n0_q;

    rat_divu #(
        .WIDTH(WIDTH)
    ) u_divu (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start_q),
        .dividend(div_dividend),
        .divisor (g_q),
        .quo     (div_quo),
        .rem     (div_rem),
        .done    (div_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            n0_q        <= '0;
            d0_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            g_q         <= '0;
            div_start_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_num_q   <= '0;
            out_den_q   <= '0;
            out_dz_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        n0_q       <= in_num;
                        d0_q       <= in_den;
                        in_ready_q <= 1'b0;
                        out_dz_q   <= 1'b0;
                        state_q    <= StCheck;
                    end
                end
                StCheck: begin
                    if (d0_q == '0) begin
                        out_num_q <= n0_q;
                        out_den_q <= '0;
                        out_dz_q  <= 1'b1;
                        state_q   <= StDone;
                    end else if (n0_q == '0) begin
                        out_num_q <= '0;
                        out_den_q <= WIDTH'(1);
                        state_q   <= StDone;
                    end else begin
                        a_q     <= n0_q;
                        b_q     <= d0_q;
                        k_q     <= '0;
                        state_q <= StStrip;
                    end
                end
                StStrip: begin
                    if (!a_q[0] && !b_q[0]) begin
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                        k_q <= k_q + KW'(1);
                    end else begin
                        state_q <= StGcd;
                    end
                end
                StGcd: begin
                    if (a_q == b_q) begin
                        g_q         <= a_q << k_q;
                        div_start_q <= 1'b1;
                        state_q     <= StDivn;
                    end else if (!a_q[0]) begin
                        a_q <= a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_q <= b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_q <= (a_q - b_q) >> 1;
                    end else begin
                        b_q <= (b_q - a_q) >> 1;
                    end
                end
                StDivn: begin
                    if (div_done) begin
                        out_num_q   <= div_quo;
                        div_start_q <= 1'b1;
                        state_q     <= StDivd;
                    end
                end
                StDivd: begin
                    if (div_done) begin
                        out_den_q <= div_quo;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // g divides both terms exactly, so any remainder means the GCD datapath is broken.
    assert property (@(posedge clk) disable iff (!rst) div_done |-> (div_rem == '0));

    assign in_ready  = in_ready_q;
    assign out_num   = out_num_q;
    assign out_den   = out_den_q;
    assign out_dz    = out_dz_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rat_reduce.sv
// Scoreboard bench for rat_reduce: directed cases plus random operands against a Euclid model.
module tb_rat_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_num = '0;
    logic [31:0] in_den = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_num;
    logic [31:0] out_den;
    logic        out_dz;
    logic        out_valid;
    logic        out_ready = 1'b1;

    typedef struct packed {
        logic [31:0] num;
        logic [31:0] den;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rat_reduce dut (
        .clk      (clk),
        .rst      (rst),
        .in_num   (in_num),
        .in_den   (in_den),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_num  (out_num),
        .out_den  (out_den),
        .out_dz   (out_dz),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp_t ref_reduce(input logic [31:0] n, input logic [31:0] d);
        exp_t e;
        logic [31:0] g;
        if (d == 0) begin
            e.num = n; e.den = 0; e.dz = 1'b1;
        end else if (n == 0) begin
            e.num = 0; e.den = 1; e.dz = 1'b0;
        end else begin
            g = ref_gcd(n, d);
            e.num = n / g; e.den = d / g; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Monitor: every transfer pops one expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0d/%0d required none", out_num, out_den);
            end else begin
                e = exp_q.pop_front();
                check("out_num", 64'(out_num), 64'(e.num));
                check("out_den", 64'(out_den), 64'(e.den));
                check("out_dz", 64'(out_dz), 64'(e.dz));
            end
        end
    end

    task automatic accept_in(input logic [31:0] n, input logic [31:0] d);
        bit acc = 1'b0;
        @(posedge clk);
        #1;
        in_num = n;
        in_den = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end
        end
        #1 in_valid = 1'b0;
        if (!acc) abort("accept_timeout");
    endtask

    // Returns edges from accept until out_valid is seen.
    task automatic run_one(input logic [31:0] n, input logic [31:0] d, output int lat);
        int busy_err = 0;
        exp_q.push_back(ref_reduce(n, d));
        accept_in(n, d);
        lat = -1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - 1;
                break;
            end
            if (in_ready) busy_err++;
        end
        if (lat < 0) abort("out_valid_timeout");
        check("in_ready_low_busy", 64'(busy_err), 64'd0);
    endtask

    task automatic wait_xfer();
        bit gone = 1'b0;
        for (int i = 0; i < 50 && !gone; i++) begin
            @(negedge clk);
            if (!out_valid) gone = 1'b1;
        end
        if (!gone) abort("transfer_timeout");
    endtask

    task automatic run_and_drain(input logic [31:0] n, input logic [31:0] d, output int lat);
        run_one(n, d, lat);
        wait_xfer();
    endtask

    initial begin : watchdog
        #900000;
        abort("watchdog");
    end

    initial begin : stim
        int lat;
        int errs;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] g;
        logic [31:0] snap_num;
        logic [31:0] snap_den;
        logic        snap_dz;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_num", 64'(out_num), 64'd0);
        check("reset_out_den", 64'(out_den), 64'd0);
        check("reset_out_dz", 64'(out_dz), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("in_ready_after_reset", 64'(in_ready), 64'd1);

        run_and_drain(32'd6, 32'd8, lat);
        run_and_drain(32'd0, 32'd5, lat);
        check("zero_num_latency", 64'(lat), 64'd2);
        run_and_drain(32'd7, 32'd0, lat);
        check("zero_den_latency", 64'(lat), 64'd2);
        run_and_drain(32'd12, 32'd12, lat);
        run_and_drain(32'd17, 32'd13, lat);
        run_and_drain(32'd1024, 32'd4096, lat);
        run_and_drain(32'hFFFF_FFFE, 32'h7FFF_FFFF, lat);
        check("wide_latency_bound", 64'(lat <= 170), 64'd1);

        // Backpressure: result must hold and a new request must not be taken.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_one(32'd100, 32'd75, lat);
        snap_num = out_num;
        snap_den = out_den;
        snap_dz = out_dz;
        @(posedge clk);
        #1;
        in_num = 32'd9;
        in_den = 32'd3;
        in_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_num !== snap_num || out_den !== snap_den || out_dz !== snap_dz ||
                out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
        end
        check("stall_stable", 64'(errs), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_xfer();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        check("stall_no_second_accept", 64'(errs), 64'd0);

        // Reset in the middle of the GCD loop discards the operation.
        accept_in(32'd360, 32'd84);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midop_reset_valid", 64'(out_valid), 64'd0);
        check("midop_reset_num", 64'(out_num), 64'd0);
        check("midop_reset_den", 64'(out_den), 64'd0);
        check("midop_reset_dz", 64'(out_dz), 64'd0);
        check("midop_reset_ready", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b1;
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) errs++;
        end
        check("midop_no_output", 64'(errs), 64'd0);
        run_and_drain(32'd360, 32'd84, lat);

        // Adder output for 1/2 + 1/6.
        run_and_drain(32'd8, 32'd12, lat);

        errs = 0;
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0: begin n = $urandom; d = 0; end
                1: begin n = 0; d = $urandom_range(1, 1000000); end
                2: begin n = $urandom; d = $urandom | 32'd1; end
                default: begin
                    g = $urandom_range(1, 1000);
                    n = g * $urandom_range(1, 2000);
                    d = g * $urandom_range(1, 2000);
                end
            endcase
            run_and_drain(n, d, lat);
            if (lat > 170) errs++;
        end
        check("random_latency_bound", 64'(errs), 64'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
